i2c_imu_responder: RTL and testbench
====================================

I2C_IMU_RESPONDER -- requirements
Module: i2c_imu_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68, 7-bit I2C target address this block answers to.
REQ-002 Parameter RESET_PTR, default 7'h3B, register pointer value after reset.
REQ-003 clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 scl_in  input  1  I2C clock from bus master, asynchronous to clk.
REQ-006 sda_inout  inout  1  I2C data line; block drives 1'b0 or 1'bz only, never 1'b1.
REQ-007 wr_en  input  1  host register-file write strobe, one cycle.
REQ-008 wr_addr  input  7  host write register index.
REQ-009 wr_data  input  8  host write data.
REQ-010 busy  output  1  high from START to STOP when addressed.
REQ-011 rd_done  output  1  one-cycle pulse at STOP ending an addressed read transfer.

Function
REQ-012 scl_in and sda_inout SHALL pass through 2-flop synchronizers; edge and condition detection uses synchronized values only.
REQ-013 START: synced SDA falls while synced SCL high; STOP: synced SDA rises while synced SCL high.
REQ-014 Register file: 128 x 8 bits; pointer 7 bits, increments mod 128 (0x7F -> 0x00).
REQ-015 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-016 Data bits sampled MSB-first on synced SCL rising edge; SDA changes only after synced SCL falling edge.
REQ-017 IDLE -> ADDR on START; START in any state (repeated start) -> ADDR, bit counter cleared, pointer retained.
REQ-018 ADDR: after 8th bit, address match -> ADDR_ACK; mismatch -> IDLE with SDA released.
REQ-019 ADDR_ACK: drive SDA 0 for one SCL period (falling edge to next falling edge); then R/W=0 -> RX_BYTE, R/W=1 -> TX_BYTE with first byte = reg[pointer].
REQ-020 RX_BYTE: first byte after address-write loads pointer; later bytes write reg[pointer] then pointer+1; every byte ACKed via RX_ACK.
REQ-021 TX_BYTE: shift out reg[pointer] latched at byte start; after 8th bit, pointer+1, release SDA -> TX_ACK.
REQ-022 TX_ACK: master ACK (SDA 0 at SCL rise) -> TX_BYTE with next byte; NACK -> IDLE-wait, SDA released until STOP/START.
REQ-023 STOP in any state -> IDLE, SDA released, busy 0; rd_done pulses if any TX byte completed since last START-to-address.
REQ-024 Host wr_en and I2C write to same register in same cycle: host write wins; I2C pointer still increments.
REQ-025 Host write to register currently being shifted SHALL NOT alter the byte in flight.
REQ-026 Clock stretching not supported; SCL never driven.

Reset
REQ-027 On reset: state IDLE, SDA released (z), busy 0, rd_done 0, pointer RESET_PTR, synchronizers to 1, register file cleared to 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately; subsequent bus activity is ignored until next START.

Verification
REQ-029 Host loads reg 0x3B..0x48 = 0x01..0x0E; master: START, 0xD0, 0x3B, repeated START, 0xD1, read 14 bytes ACK, last NACK, STOP -> bytes 0x01..0x0E, 3 ACKs from block, rd_done one pulse, pointer 0x49.
REQ-030 START, 0xD2 (addr 0x69) -> no ACK (SDA z at 9th SCL), busy 0, no register change.
REQ-031 START, 0xD0, 0x7F, 0xAA, 0xBB, STOP -> reg 0x7F=0xAA, reg 0x00=0xBB, pointer 0x01.
REQ-032 Reset asserted during 4th data bit of a read byte -> SDA z next cycle, busy 0, pointer 0x3B; following full read transaction correct.
REQ-033 Host wr_en to reg 0x40=0x55 coincident with I2C write of 0x40=0x99 -> reg 0x40 reads 0x55.
REQ-034 STOP mid-byte during RX_BYTE -> IDLE, partial byte discarded, no register written.

Source files
------------

// File: rtl/i2c_imu_responder.sv
// rtl/i2c_imu_responder.sv - I2C target exposing a 128x8 register file with an auto-incrementing pointer
module i2c_imu_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h68,
  parameter logic [6:0] RESET_PTR = 7'h3B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  inout  wire        sda_inout,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       rd_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_RX_BYTE  = 3'd3;
  localparam logic [2:0] S_RX_ACK   = 3'd4;
  localparam logic [2:0] S_TX_BYTE  = 3'd5;
  localparam logic [2:0] S_TX_ACK   = 3'd6;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1; scl_sync_q <= 1'b1; scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1; sda_sync_q <= 1'b1; sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;     scl_sync_q <= scl_meta_q; scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_inout;  sda_sync_q <= sda_meta_q; sda_prev_q <= sda_sync_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] ptr_q, ptr_d;
  logic       rw_q, rw_d, first_q, first_d, tx_done_q, tx_done_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d, rd_done_q, rd_done_d;
  logic       i2c_we;
  logic [7:0] mem_q [128];
  logic [7:0] byte_in, mem_rd;

  assign byte_in = {shift_q[6:0], sda_sync_q};
  assign mem_rd  = mem_q[ptr_q];

  always_comb begin
    state_d = state_q; bit_cnt_d = bit_cnt_q; shift_d = shift_q; ptr_d = ptr_q;
    rw_d = rw_q; first_d = first_q; tx_done_d = tx_done_q;
    sda_oe_d = sda_oe_q; busy_d = busy_q; rd_done_d = 1'b0; i2c_we = 1'b0;
    if (stop_det) begin
      state_d = S_IDLE; sda_oe_d = 1'b0; busy_d = 1'b0;
      rd_done_d = busy_q & tx_done_q; tx_done_d = 1'b0;
    end else if (start_det) begin
      state_d = S_ADDR; bit_cnt_d = '0; sda_oe_d = 1'b0; tx_done_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = byte_in; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = S_ADDR_ACK; rw_d = byte_in[0]; first_d = 1'b1; busy_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        // ACK phases: first falling edge asserts SDA, the next one ends the ACK bit
        S_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d = mem_rd; sda_oe_d = ~mem_rd[7]; state_d = S_TX_BYTE; bit_cnt_d = '0;
          end else begin
            sda_oe_d = 1'b0; state_d = S_RX_BYTE; bit_cnt_d = '0;
          end
        end
        S_RX_BYTE: if (scl_rise) begin
          shift_d = byte_in; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0; state_d = S_RX_ACK;
            if (first_q) begin
              ptr_d = byte_in[6:0]; first_d = 1'b0;
            end else begin
              i2c_we = 1'b1; ptr_d = ptr_q + 7'd1;
            end
          end
        end
        S_RX_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0; state_d = S_RX_BYTE;
          end
        end
        S_TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0; ptr_d = ptr_q + 7'd1; tx_done_d = 1'b1; state_d = S_TX_ACK;
            end
          end else if (scl_fall && bit_cnt_q != 3'd0) begin
            shift_d = {shift_q[6:0], shift_q[7]}; sda_oe_d = ~shift_q[6];
          end
        end
        // bit_cnt_q == 1 marks a master ACK already sampled in this ACK slot
        S_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_sync_q) bit_cnt_d = 3'd1;
            else begin
              state_d = S_IDLE; sda_oe_d = 1'b0;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd1) begin
              shift_d = mem_rd; sda_oe_d = ~mem_rd[7]; state_d = S_TX_BYTE; bit_cnt_d = '0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; bit_cnt_q <= '0; shift_q <= '0; ptr_q <= RESET_PTR;
      rw_q <= 1'b0; first_q <= 1'b0; tx_done_q <= 1'b0;
      sda_oe_q <= 1'b0; busy_q <= 1'b0; rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; shift_q <= shift_d; ptr_q <= ptr_d;
      rw_q <= rw_d; first_q <= first_d; tx_done_q <= tx_done_d;
      sda_oe_q <= sda_oe_d; busy_q <= busy_d; rd_done_q <= rd_done_d;
    end
  end

  // Host port has priority when both sides target the same register in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= '0;
    end else begin
      if (i2c_we && !(wr_en && wr_addr == ptr_q)) mem_q[ptr_q] <= byte_in;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  assign sda_inout = sda_oe_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_i2c_imu_responder.sv
// tb/tb_i2c_imu_responder.sv - directed bus-master bench for i2c_imu_responder
module tb_i2c_imu_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic       wr_en = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy, rd_done;
  wire        sda;

  logic [6:0] hh_addr = '0;
  logic [7:0] hh_data = '0;
  int n_checks = 0;
  int n_fail = 0;
  int rd_pulses = 0;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_imu_responder dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_inout(sda),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .rd_done(rd_done)
  );

  always @(negedge clk) if (rd_done) rd_pulses <= rd_pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic i2c_start;
    m_oe = 1'b0; wait_q; scl = 1'b1; wait_q; m_oe = 1'b1; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic i2c_stop;
    m_oe = 1'b1; wait_q; scl = 1'b1; wait_q; m_oe = 1'b0; wait_q;
  endtask

  // hh: pulse the host write port exactly in the cycle the target commits this byte
  task automatic write_bit(input logic b, input logic hh);
    m_oe = ~b; wait_q; scl = 1'b1;
    if (hh) begin
      repeat (2) @(negedge clk);
      wr_en = 1'b1; wr_addr = hh_addr; wr_data = hh_data;
      @(negedge clk); wr_en = 1'b0;
      repeat (2 * Q - 3) @(negedge clk);
    end else begin
      wait_q; wait_q;
    end
    scl = 1'b0; wait_q;
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; wait_q; scl = 1'b1; wait_q; b = sda; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic hh, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], hh && i == 0);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic       ack, b;
    logic [7:0] d;
    int         p0;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_done", rd_done, 1'b0);
    check("rst_sda", sda, 1'b1);
    check("rst_ptr", dut.ptr_q, 7'h3B);

    // burst read of 14 registers after a pointer write and repeated START
    for (int i = 0; i < 14; i++) host_wr(7'h3B + 7'(i), 8'(i + 1));
    p0 = rd_pulses;
    i2c_start;
    write_byte(8'hD0, 1'b0, ack); check("ack_addr_w", ack, 1'b1);
    check("busy_addressed", busy, 1'b1);
    write_byte(8'h3B, 1'b0, ack); check("ack_ptr", ack, 1'b1);
    i2c_start;
    write_byte(8'hD1, 1'b0, ack); check("ack_addr_r", ack, 1'b1);
    for (int i = 0; i < 14; i++) begin
      read_byte(i == 13, d);
      check($sformatf("burst_byte%0d", i), d, 8'(i + 1));
    end
    i2c_stop;
    repeat (4) @(negedge clk);
    check("burst_rd_done_pulses", rd_pulses - p0, 1);
    check("burst_ptr", dut.ptr_q, 7'h49);
    check("burst_busy_after", busy, 1'b0);

    // wrong address
    i2c_start;
    write_byte(8'hD2, 1'b0, ack); check("nack_wrong_addr", ack, 1'b0);
    check("wrong_addr_busy", busy, 1'b0);
    i2c_stop;
    repeat (4) @(negedge clk);
    check("wrong_addr_ptr", dut.ptr_q, 7'h49);
    check("wrong_addr_reg", dut.mem_q[7'h3B], 8'h01);

    // write across pointer wrap
    p0 = rd_pulses;
    i2c_start;
    write_byte(8'hD0, 1'b0, ack); check("wrap_ack_addr", ack, 1'b1);
    write_byte(8'h7F, 1'b0, ack); check("wrap_ack_ptr", ack, 1'b1);
    write_byte(8'hAA, 1'b0, ack); check("wrap_ack_d0", ack, 1'b1);
    write_byte(8'hBB, 1'b0, ack); check("wrap_ack_d1", ack, 1'b1);
    i2c_stop;
    repeat (4) @(negedge clk);
    check("wrap_reg7f", dut.mem_q[7'h7F], 8'hAA);
    check("wrap_reg00", dut.mem_q[7'h00], 8'hBB);
    check("wrap_ptr", dut.ptr_q, 7'h01);
    check("wrap_no_rd_done", rd_pulses - p0, 0);

    // host write collides with I2C write to the same register
    hh_addr = 7'h40; hh_data = 8'h55;
    i2c_start;
    write_byte(8'hD0, 1'b0, ack);
    write_byte(8'h40, 1'b0, ack);
    write_byte(8'h99, 1'b1, ack); check("collide_ack", ack, 1'b1);
    i2c_stop;
    repeat (4) @(negedge clk);
    check("collide_reg40", dut.mem_q[7'h40], 8'h55);
    check("collide_ptr", dut.ptr_q, 7'h41);

    // STOP in the middle of a received byte
    host_wr(7'h10, 8'h3C);
    i2c_start;
    write_byte(8'hD0, 1'b0, ack);
    write_byte(8'h10, 1'b0, ack);
    write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0); write_bit(1'b1, 1'b0); write_bit(1'b1, 1'b0);
    i2c_stop;
    repeat (4) @(negedge clk);
    check("partial_reg10", dut.mem_q[7'h10], 8'h3C);
    check("partial_ptr", dut.ptr_q, 7'h10);
    check("partial_busy", busy, 1'b0);

    // reset during the 4th bit of a read byte, then a clean read
    i2c_start;
    write_byte(8'hD0, 1'b0, ack);
    write_byte(8'h3B, 1'b0, ack);
    i2c_start;
    write_byte(8'hD1, 1'b0, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    m_oe = 1'b0; wait_q; scl = 1'b1; wait_q;
    check("pre_reset_sda", sda, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_sda_released", sda, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ptr", dut.ptr_q, 7'h3B);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_regs_cleared", dut.mem_q[7'h7F], 8'h00);
    wait_q; scl = 1'b0; wait_q;
    host_wr(7'h3B, 8'hA1); host_wr(7'h3C, 8'hA2); host_wr(7'h3D, 8'hA3);
    p0 = rd_pulses;
    i2c_start;
    write_byte(8'hD0, 1'b0, ack); check("post_ack_addr", ack, 1'b1);
    write_byte(8'h3B, 1'b0, ack);
    i2c_start;
    write_byte(8'hD1, 1'b0, ack); check("post_ack_rd", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d);
      check($sformatf("post_byte%0d", i), d, 8'hA1 + 8'(i));
    end
    i2c_stop;
    repeat (4) @(negedge clk);
    check("post_rd_done_pulses", rd_pulses - p0, 1);
    check("post_ptr", dut.ptr_q, 7'h3E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
